// File: rtl/i3c_ddr_pkg.sv
// Shared HDR-DDR definitions for the I3C TX/RX paths.
// Mode codes, CRC token, widths and the TX state encoding.
package i3c_ddr_pkg;

  localparam int DATA_W = 8;
  localparam int CRC_W  = 5;

  localparam logic [3:0] CRC_TOKEN = 4'b1100;

  localparam logic [3:0] MODE_PRE_ONE  = 4'b0000;
  localparam logic [3:0] MODE_PRE_ZERO = 4'b0001;
  localparam logic [3:0] MODE_BYTE     = 4'b0011;
  localparam logic [3:0] MODE_TOKEN    = 4'b0101;
  localparam logic [3:0] MODE_PARITY   = 4'b0110;
  localparam logic [3:0] MODE_CRC      = 4'b0111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_WAIT_CRC,
    ST_DONE
  } tx_state_e;

  // Bits sent for a mode; 0 marks an unsupported code.
  function automatic logic [3:0] mode_len(
    input logic [3:0] m
  );
    logic [3:0] n;
    n = 4'd0;
    unique case (1'b1)
      (m == MODE_PRE_ONE):  n = 4'd1;
      (m == MODE_PRE_ZERO): n = 4'd1;
      (m == MODE_BYTE):     n = 4'd8;
      (m == MODE_TOKEN):    n = 4'd4;
      (m == MODE_PARITY):   n = 4'd2;
      (m == MODE_CRC):      n = 4'd5;
      default:              n = 4'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ddr_tx_if.sv
// Control/data bundle between the DDR CCC side and ddr_tx.
// Readback input exists only with DDR_TX_READBACK_EN.
interface ddr_tx_if;
  import i3c_ddr_pkg::*;

  logic              i_sclgen_scl_pos_edge;
  logic              i_sclgen_scl_neg_edge;
  logic              i_ddrccc_tx_en;
  logic [3:0]        i_ddrccc_tx_mode;
  logic [DATA_W-1:0] i_regf_tx_data;
  logic [CRC_W-1:0]  i_crc_value;
  logic              i_crc_valid;
`ifdef DDR_TX_READBACK_EN
  logic              i_sdahnd_rx_sda;
`endif
  logic              o_sdahnd_tx_sda;
  logic              o_ddrccc_tx_mode_done;
  logic              o_crc_en;
  logic [DATA_W-1:0] o_crc_data;
  logic              o_crc_data_valid;
  logic              o_ddrccc_tx_error;

  modport master (
`ifdef DDR_TX_READBACK_EN
    output i_sdahnd_rx_sda,
`endif
    output i_sclgen_scl_pos_edge,
    output i_sclgen_scl_neg_edge,
    output i_ddrccc_tx_en,
    output i_ddrccc_tx_mode,
    output i_regf_tx_data,
    output i_crc_value,
    output i_crc_valid,
    input  o_sdahnd_tx_sda,
    input  o_ddrccc_tx_mode_done,
    input  o_crc_en,
    input  o_crc_data,
    input  o_crc_data_valid,
    input  o_ddrccc_tx_error
  );

  modport slave (
`ifdef DDR_TX_READBACK_EN
    input  i_sdahnd_rx_sda,
`endif
    input  i_sclgen_scl_pos_edge,
    input  i_sclgen_scl_neg_edge,
    input  i_ddrccc_tx_en,
    input  i_ddrccc_tx_mode,
    input  i_regf_tx_data,
    input  i_crc_value,
    input  i_crc_valid,
    output o_sdahnd_tx_sda,
    output o_ddrccc_tx_mode_done,
    output o_crc_en,
    output o_crc_data,
    output o_crc_data_valid,
    output o_ddrccc_tx_error
  );

endinterface

// File: rtl/ddr_parity_gen.sv
// 16-bit DDR word accumulator producing PA1/PA0.
// First byte loaded lands in D[15:8], second in D[7:0].
module ddr_parity_gen
  import i3c_ddr_pkg::*;
(
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_load,
  input  logic              i_clr,
  input  logic [DATA_W-1:0] i_byte,
  output logic              o_pa1,
  output logic              o_pa0
);

  logic [2*DATA_W-1:0] word_q;

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      word_q <= '0;
    end else if (i_clr) begin
      word_q <= '0;
    end else if (i_load) begin
      word_q <= {word_q[DATA_W-1:0], i_byte};
    end
  end

  always_comb begin
    o_pa1 = 1'b0;
    o_pa0 = 1'b1;
    for (int i = 0; i < DATA_W; i++) begin
      o_pa1 = o_pa1 ^ word_q[2*i+1];
      o_pa0 = o_pa0 ^ word_q[2*i];
    end
  end

endmodule

// File: rtl/ddr_tx.sv
// HDR-DDR transmit serializer: one SDA bit per SCL edge.
// DDR_TX_READBACK_EN adds SDA readback checking.
module ddr_tx
  import i3c_ddr_pkg::*;
(
  input logic   i_sys_clk,
  input logic   i_sys_rst,
  ddr_tx_if.slave bus
);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [3:0]        mode_q, mode_d;
  logic              sda_q, sda_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] crcd_q, crcd_d;
  logic              crcv_q, crcv_d;
  logic              err_q, err_d;

  logic              en;
  logic              edge_hit;
  logic [3:0]        mode;
  logic [3:0]        len;
  logic [DATA_W-1:0] op;
  logic              pa1, pa0;
  logic              par_load, par_clr;
  logic              rb_bad;

  assign en       = bus.i_ddrccc_tx_en;
  assign mode     = bus.i_ddrccc_tx_mode;
  assign edge_hit = bus.i_sclgen_scl_pos_edge
                  | bus.i_sclgen_scl_neg_edge;
  assign len      = mode_len(mode);

`ifdef DDR_TX_READBACK_EN
  assign rb_bad = bus.i_sdahnd_rx_sda != sda_q;
`else
  assign rb_bad = 1'b0;
`endif

  ddr_parity_gen u_par (
    .i_sys_clk (i_sys_clk),
    .i_sys_rst (i_sys_rst),
    .i_load    (par_load),
    .i_clr     (par_clr),
    .i_byte    (shreg_q),
    .o_pa1     (pa1),
    .o_pa0     (pa0)
  );

  // Operand right-aligned; bit len-1 goes out first.
  always_comb begin
    op = '0;
    unique case (1'b1)
      (mode == MODE_PRE_ONE):
        op = 8'h01;
      (mode == MODE_BYTE):
        op = bus.i_regf_tx_data;
      (mode == MODE_TOKEN):
        op = {4'b0000, CRC_TOKEN};
      (mode == MODE_PARITY):
        op = {6'b000000, pa1, pa0};
      (mode == MODE_CRC):
        op = {{(DATA_W-CRC_W){1'b0}},
              bus.i_crc_value};
      default:
        op = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    sda_d    = sda_q;
    pend_d   = pend_q;
    crcd_d   = crcd_q;
    crcv_d   = 1'b0;
    err_d    = err_q;
    par_load = 1'b0;
    par_clr  = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      sda_d   = 1'b1;
      cnt_d   = '0;
      pend_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_LOAD;
        ST_LOAD: begin
          mode_d  = mode;
          shreg_d = op;
          cnt_d   = (len == 4'd0) ? 3'd0
                  : 3'(len - 4'd1);
          pend_d  = 1'b0;
          if (len == 4'd0) begin
            sda_d = 1'b1;
          end else if (mode == MODE_CRC
                       && !bus.i_crc_valid) begin
            state_d = ST_WAIT_CRC;
          end else if (edge_hit) begin
            sda_d   = op[3'(len - 4'd1)];
            state_d = ST_SHIFT;
          end
        end
        // First SHIFT edge after the wait drives the MSB.
        ST_WAIT_CRC: begin
          if (bus.i_crc_valid) begin
            shreg_d = {{(DATA_W-CRC_W){1'b0}},
                       bus.i_crc_value};
            cnt_d   = 3'(CRC_W - 1);
            pend_d  = 1'b1;
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (edge_hit) begin
            if (!pend_q && rb_bad) err_d = 1'b1;
            if (pend_q) begin
              sda_d  = shreg_q[cnt_q];
              pend_d = 1'b0;
            end else if (cnt_q == 3'd0) begin
              state_d = ST_DONE;
              if (mode_q == MODE_BYTE) begin
                crcd_d   = shreg_q;
                crcv_d   = 1'b1;
                par_load = 1'b1;
              end
              par_clr = (mode_q == MODE_PARITY);
            end else begin
              sda_d = shreg_q[3'(cnt_q - 3'd1)];
              cnt_d = 3'(cnt_q - 3'd1);
            end
          end
        end
        ST_DONE: state_d = ST_LOAD;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      sda_q   <= 1'b1;
      pend_q  <= 1'b0;
      crcd_q  <= '0;
      crcv_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      sda_q   <= sda_d;
      pend_q  <= pend_d;
      crcd_q  <= crcd_d;
      crcv_q  <= crcv_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_sdahnd_tx_sda       = sda_q;
  assign bus.o_ddrccc_tx_mode_done = state_q == ST_DONE;
  assign bus.o_crc_data            = crcd_q;
  assign bus.o_crc_data_valid      = crcv_q;

  // LOAD has not latched the mode yet, so look at it live.
  assign bus.o_crc_en =
      (state_q == ST_LOAD && mode == MODE_BYTE)
    || ((state_q == ST_SHIFT || state_q == ST_DONE)
        && mode_q == MODE_BYTE);

`ifdef DDR_TX_READBACK_EN
  assign bus.o_ddrccc_tx_error = err_q;
`else
  assign bus.o_ddrccc_tx_error = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_tx.sv
// Directed scoreboard bench for ddr_tx.
// Expected SDA bits and CRC bytes are queued at launch.
module tb_ddr_tx;
  import i3c_ddr_pkg::*;

  logic i_sys_clk_tb = 1'b0;
  logic rst_n = 1'b0;
  always #10 i_sys_clk_tb = ~i_sys_clk_tb;

  ddr_tx_if bus();

  ddr_tx dut (
    .i_sys_clk (i_sys_clk_tb),
    .i_sys_rst (rst_n),
    .bus       (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          done_seen = 0;
  int          done_exp = 0;
  logic        pol = 1'b0;
  logic [15:0] w_model = '0;
  logic        exp_sda_q[$];
  logic [7:0]  exp_crc_q[$];

`ifdef DDR_TX_READBACK_EN
  logic rb_force = 1'b0;
  assign bus.i_sdahnd_rx_sda =
    rb_force ? 1'b0 : bus.o_sdahnd_tx_sda;
`endif

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] par_model(
    input logic [15:0] w
  );
    logic a, b;
    a = 1'b0;
    b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = a ^ w[2*i+1];
      b = b ^ w[2*i];
    end
    return {a, b};
  endfunction

  always @(negedge i_sys_clk_tb) begin
    if (bus.o_ddrccc_tx_mode_done) done_seen++;
    if (bus.o_crc_data_valid) begin
      if (exp_crc_q.size() == 0)
        chk("crc_unexp", 8'(bus.o_crc_data_valid), 8'd0);
      else
        chk("crc_data", bus.o_crc_data,
            exp_crc_q.pop_front());
    end
  end

  task automatic edge_step(input logic both,
                           output logic s,
                           output logic d);
    @(posedge i_sys_clk_tb); #1;
    if (both) begin
      bus.i_sclgen_scl_pos_edge = 1'b1;
      bus.i_sclgen_scl_neg_edge = 1'b1;
    end else if (pol) begin
      bus.i_sclgen_scl_neg_edge = 1'b1;
    end else begin
      bus.i_sclgen_scl_pos_edge = 1'b1;
    end
    pol = ~pol;
    @(posedge i_sys_clk_tb); #1;
    bus.i_sclgen_scl_pos_edge = 1'b0;
    bus.i_sclgen_scl_neg_edge = 1'b0;
    @(negedge i_sys_clk_tb);
    s = bus.o_sdahnd_tx_sda;
    d = bus.o_ddrccc_tx_mode_done;
  endtask

  task automatic run_bits(input logic [7:0] bits,
                          input int n,
                          input logic dbl);
    logic s, d;
    for (int i = n - 1; i >= 0; i--)
      exp_sda_q.push_back(bits[i]);
    for (int i = 0; i < n; i++) begin
      edge_step(dbl && i == 1, s, d);
      chk("sda", 8'(s), 8'(exp_sda_q.pop_front()));
      chk("done_early", 8'(d), 8'd0);
    end
    edge_step(1'b0, s, d);
    chk("done", 8'(d), 8'd1);
    chk("sda_hold", 8'(s), 8'(bits[0]));
    done_exp++;
  endtask

  task automatic run_mode(input logic [3:0] m,
                          input logic [7:0] dat,
                          input logic [7:0] bits,
                          input int n);
    bus.i_ddrccc_tx_mode = m;
    bus.i_regf_tx_data   = dat;
    bus.i_ddrccc_tx_en   = 1'b1;
    if (m == MODE_BYTE) exp_crc_q.push_back(dat);
    repeat (3) @(posedge i_sys_clk_tb);
    #1;
    chk("crc_en", 8'(bus.o_crc_en), 8'(m == MODE_BYTE));
    run_bits(bits, n, m == MODE_TOKEN);
    if (m == MODE_BYTE) w_model = {w_model[7:0], dat};
    if (m == MODE_PARITY) w_model = '0;
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic       s, d;
    logic [1:0] pb;
    bus.i_sclgen_scl_pos_edge = 1'b0;
    bus.i_sclgen_scl_neg_edge = 1'b0;
    bus.i_ddrccc_tx_en        = 1'b0;
    bus.i_ddrccc_tx_mode      = 4'h0;
    bus.i_regf_tx_data        = 8'h00;
    bus.i_crc_value           = 5'h00;
    bus.i_crc_valid           = 1'b0;

    repeat (3) @(posedge i_sys_clk_tb);
    @(negedge i_sys_clk_tb);
    chk("rst_sda", 8'(bus.o_sdahnd_tx_sda), 8'd1);
    chk("rst_done", 8'(bus.o_ddrccc_tx_mode_done), 8'd0);
    chk("rst_crc_en", 8'(bus.o_crc_en), 8'd0);
    chk("rst_crc_data", bus.o_crc_data, 8'h00);
    chk("rst_crc_vld", 8'(bus.o_crc_data_valid), 8'd0);
    chk("rst_err", 8'(bus.o_ddrccc_tx_error), 8'd0);
    rst_n = 1'b1;

    run_mode(MODE_PRE_ZERO, 8'h00, 8'h00, 1);
    run_mode(MODE_PRE_ONE, 8'h00, 8'h01, 1);
    run_mode(MODE_BYTE, 8'hA1, 8'hA1, 8);
    run_mode(MODE_BYTE, 8'hD4, 8'hD4, 8);
    pb = par_model(w_model);
    run_mode(MODE_PARITY, 8'h00, {6'b0, pb}, 2);
    pb = par_model(w_model);
    run_mode(MODE_PARITY, 8'h00, {6'b0, pb}, 2);
    run_mode(MODE_TOKEN, 8'h00, {4'b0, CRC_TOKEN}, 4);

    // CRC result arrives late; edges in between are ignored.
    bus.i_ddrccc_tx_mode = MODE_CRC;
    bus.i_crc_valid = 1'b0;
    repeat (3) @(posedge i_sys_clk_tb);
    for (int i = 0; i < 3; i++) begin
      edge_step(1'b0, s, d);
      chk("crc_wait_sda", 8'(s), 8'd0);
      chk("crc_wait_done", 8'(d), 8'd0);
    end
    @(posedge i_sys_clk_tb); #1;
    bus.i_crc_value = 5'b10101;
    bus.i_crc_valid = 1'b1;
    repeat (2) @(posedge i_sys_clk_tb);
    #1;
    bus.i_crc_valid = 1'b0;
    run_bits(8'b0001_0101, 5, 1'b0);

    bus.i_ddrccc_tx_mode = MODE_BYTE;
    bus.i_regf_tx_data   = 8'hFF;
    repeat (3) @(posedge i_sys_clk_tb);
    for (int i = 0; i < 3; i++) begin
      edge_step(1'b0, s, d);
      chk("abort_bit", 8'(s), 8'd1);
    end
    bus.i_ddrccc_tx_en = 1'b0;
    @(negedge i_sys_clk_tb);
    chk("abort_sda", 8'(bus.o_sdahnd_tx_sda), 8'd1);
    for (int i = 0; i < 6; i++) begin
      edge_step(1'b0, s, d);
      chk("abort_done", 8'(d), 8'd0);
    end
    chk("abort_crc_en", 8'(bus.o_crc_en), 8'd0);

`ifdef DDR_TX_READBACK_EN
    rb_force = 1'b1;
    run_mode(MODE_BYTE, 8'hFF, 8'hFF, 8);
    chk("rb_err", 8'(bus.o_ddrccc_tx_error), 8'd1);
    rb_force = 1'b0;
    bus.i_ddrccc_tx_en = 1'b0;
    repeat (2) @(negedge i_sys_clk_tb);
    chk("rb_err_clr", 8'(bus.o_ddrccc_tx_error), 8'd0);
`else
    run_mode(MODE_BYTE, 8'hFF, 8'hFF, 8);
    chk("err_tied", 8'(bus.o_ddrccc_tx_error), 8'd0);
    bus.i_ddrccc_tx_en = 1'b0;
`endif

    repeat (4) @(negedge i_sys_clk_tb);
    chk("done_count", 8'(done_seen), 8'(done_exp));
    chk("crc_left", 8'(exp_crc_q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ddr_tx.md
Name: ddr_tx

Overview:
- HDR-DDR transmit serializer for the I3C controller. It is the counterpart of the RX deserializer.
- The DDR CCC FSM selects a mode. The block then drives SDA one bit per SCL edge (pos and neg), taking edge pulses from scl_generation.
- Covers preamble bits, data bytes, parity, CRC token and CRC value.
- Feeds transmitted bytes to the CRC engine and accumulates word parity internally.

Parameters:
- DATA_W, 8, data byte width.
- CRC_W, 5, CRC value width.
- CRC_TOKEN, 4'b1100, CRC token pattern, sent MSB first.

Ports:
- i_sys_clk  in  1  system clock, 50 MHz.
- i_sys_rst  in  1  asynchronous active-low reset.
- i_sclgen_scl_pos_edge  in  1  one-cycle pulse at SCL rise.
- i_sclgen_scl_neg_edge  in  1  one-cycle pulse at SCL fall.
- i_ddrccc_tx_en  in  1  enable; low aborts the current mode.
- i_ddrccc_tx_mode  in  4  mode select.
- i_regf_tx_data  in  8  byte to serialize.
- i_crc_value  in  5  CRC result.
- i_crc_valid  in  1  CRC result ready.
- o_sdahnd_tx_sda  out  1  serial data to the SDA handler.
- o_ddrccc_tx_mode_done  out  1  one-cycle pulse when a mode completes.
- o_crc_en  out  1  CRC engine enable.
- o_crc_data  out  8  byte presented to CRC.
- o_crc_data_valid  out  1  one-cycle strobe for o_crc_data.
- o_ddrccc_tx_error  out  1  readback mismatch flag (macro only; tied 0 otherwise).

Behaviour:
- Reset values: o_sdahnd_tx_sda=1; all other outputs 0. Parity accumulator, shift register and bit counter cleared.
- Modes:
  - 0000 PRE_ONE: 1 bit, value 1.
  - 0001 PRE_ZERO: 1 bit, value 0.
  - 0011 BYTE: 8 bits, MSB first.
  - 0101 TOKEN: 4 bits, CRC_TOKEN.
  - 0110 PARITY: 2 bits, PA1 then PA0.
  - 0111 CRC: 5 bits, i_crc_value MSB first.
  - Other codes: SDA held 1, no done pulse.
- FSM states: IDLE, LOAD, SHIFT, WAIT_CRC, DONE.
- IDLE→LOAD: on en=1. In LOAD, mode and operand are latched into the shift register and bit counter = N-1.
- LOAD→SHIFT: on the first edge pulse (pos or neg). That edge drives bit N-1 onto o_sdahnd_tx_sda, registered, visible the next cycle. Each further edge drives the next bit and decrements the counter.
- SHIFT→DONE: on the edge after the last bit is driven. o_ddrccc_tx_mode_done pulses for one cycle, SDA holds the last bit, then the FSM returns to LOAD if en=1, else IDLE.
  - The mode change from CCC is sampled in the cycle after the done pulse.
- CRC mode with i_crc_valid=0: enter WAIT_CRC, ignore edges, hold SDA. On i_crc_valid=1 latch i_crc_value and go to SHIFT.
- BYTE mode:
  - o_crc_en is high from LOAD through DONE.
  - On DONE, o_crc_data = byte and o_crc_data_valid pulses once.
  - The byte is shifted into the 16-bit parity word; the first byte becomes D[15:8], the second D[7:0].
- PARITY mode:
  - PA1 = XOR of odd bits D15..D1.
  - PA0 = XOR of even bits D14..D0, XOR 1.
  - Accumulator clears at PARITY mode done.
- en deasserted mid-mode: abort next cycle, SDA=1, counter cleared, no done pulse, parity accumulator retained.
- Pos and neg pulse in the same cycle (cannot occur): treat as a single edge.
- Reset mid-mode: immediate return to reset values.

Optional Feature:
- Macro DDR_TX_READBACK_EN.
- Defined:
  - Adds input i_sdahnd_rx_sda.
  - On each edge after the first in SHIFT, compare i_sdahnd_rx_sda with the bit driven on the previous edge.
  - On mismatch, set o_ddrccc_tx_error (sticky until en low or reset) and complete the mode normally.
- Undefined: the input is absent and o_ddrccc_tx_error is tied 0.

Decomposition:
- Package i3c_ddr_pkg: mode codes (shared with RX), CRC_TOKEN, state enum, DATA_W/CRC_W constants.
- Sub-module ddr_parity_gen: 16-bit word accumulator with PA1/PA0 outputs, load-byte and clear strobes.

Test Plan:
- PRE_ZERO then PRE_ONE, en=1 → SDA 0 then 1 on successive edges; one done pulse after each.
- BYTE 0xA1 then BYTE 0xD4:
  - SDA sequence 1,0,1,0,0,0,0,1 then 1,1,0,1,0,1,0,0.
  - o_crc_data_valid pulses with 0xA1, then 0xD4.
- PARITY after word 0xA1D4 → SDA 1,1; accumulator clear afterwards.
- TOKEN → SDA 1,1,0,0.
- CRC with i_crc_valid held low 10 cycles, then high with i_crc_value=5'b10101:
  - No SDA change during the wait.
  - Then SDA 1,0,1,0,1; done pulse after the last bit.
- en dropped after 3 bits of BYTE 0xFF → SDA=1 next cycle, no done pulse, no o_crc_data_valid.
- With DDR_TX_READBACK_EN, force readback 0 during BYTE 0xFF → o_ddrccc_tx_error=1; done still pulses.
